// File: rtl/ps2_link.sv
// PS/2 host link layer: filtered open-drain line sampling, 11-bit frame receive into a FIFO,
// and host-to-device command transmit with inhibit / request-to-send sequencing.
module ps2_link #(
  parameter int FILTER         = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  output logic       ps2_clk_oe,
  input  logic       ps2_data_in,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_byte,
  output logic       tx_done_valid,
  output logic       tx_done_error,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_error,
  output logic       rx_overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int FW   = $clog2(FILTER + 1);
  localparam int TMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, RX, TX_INHIBIT, TX_REQUEST, TX_BITS, TX_ACK, TX_RELEASE
  } state_t;

  state_t state, state_next;

  // Bit 0 = clock line, bit 1 = data line.
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          filt_clk_d, fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      filt       <= 2'b11;
      fcnt[0]    <= '0;
      fcnt[1]    <= '0;
      filt_clk_d <= 1'b1;
    end else begin
      sync1      <= {ps2_data_in, ps2_clk_in};
      sync2      <= sync1;
      filt_clk_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall = filt_clk_d & ~filt[0];

  logic [CW-1:0] tcnt;
  logic          timeout, inhibit_done;
  logic [3:0]    rx_idx, tx_cnt;
  logic [10:0]   rx_shift;
  logic [8:0]    tx_shift;
  logic [7:0]    tx_data;
  logic          tx_pending, ack_err, rx_done, rx_to;
  logic          rx_to_set, done_set, done_err;

  assign timeout      = (tcnt == CW'(TIMEOUT_CYCLES - 1));
  assign inhibit_done = (tcnt == CW'(INHIBIT_CYCLES - 1));

  always_comb begin
    state_next = state;
    rx_to_set  = 1'b0;
    done_set   = 1'b0;
    done_err   = 1'b0;
    case (state)
      IDLE: begin
        if (fall)          state_next = RX;
        else if (tx_valid) state_next = TX_INHIBIT;
      end
      RX: begin
        if (fall && rx_idx == 4'd10) begin
          state_next = tx_pending ? TX_INHIBIT : IDLE;
        end else if (timeout) begin
          rx_to_set  = 1'b1;
          state_next = tx_pending ? TX_INHIBIT : IDLE;
        end
      end
      TX_INHIBIT: if (inhibit_done) state_next = TX_REQUEST;
      TX_REQUEST, TX_BITS, TX_ACK, TX_RELEASE: begin
        if (state == TX_REQUEST && fall) begin
          state_next = TX_BITS;
        end else if (state == TX_BITS && fall && tx_cnt == 4'd8) begin
          state_next = TX_ACK;
        end else if (state == TX_ACK && fall) begin
          state_next = TX_RELEASE;
        end else if (state == TX_RELEASE && filt == 2'b11) begin
          state_next = IDLE;
          done_set   = 1'b1;
          done_err   = ack_err;
        end else if (timeout) begin
          state_next = IDLE;
          done_set   = 1'b1;
          done_err   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tcnt          <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_done       <= 1'b0;
      rx_to         <= 1'b0;
      tx_pending    <= 1'b0;
      tx_data       <= '0;
      tx_shift      <= '0;
      tx_cnt        <= '0;
      ack_err       <= 1'b0;
      tx_done_valid <= 1'b0;
      tx_done_error <= 1'b0;
    end else begin
      state         <= state_next;
      rx_done       <= (state == RX) && fall && (rx_idx == 4'd10);
      rx_to         <= rx_to_set;
      tx_done_valid <= done_set;
      tx_done_error <= done_set & done_err;
      // Inhibit holds the clock low, so the resulting edge must not restart the inhibit count.
      if (state == IDLE || state_next != state || (fall && state != TX_INHIBIT)) tcnt <= '0;
      else                                                                      tcnt <= tcnt + 1'b1;
      if ((state == IDLE || state == RX) && fall) begin
        rx_shift <= {filt[1], rx_shift[10:1]};
        rx_idx   <= (state == IDLE) ? 4'd1 : rx_idx + 4'd1;
      end
      if (state == IDLE && tx_valid) begin
        tx_pending <= 1'b1;
        tx_data    <= tx_byte;
      end else if (state == TX_INHIBIT) begin
        tx_pending <= 1'b0;
      end
      if (state == TX_REQUEST && fall) begin
        tx_shift <= {~^tx_data, tx_data};
        tx_cnt   <= '0;
      end else if (state == TX_BITS && fall) begin
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_cnt   <= tx_cnt + 4'd1;
      end
      if (state == TX_ACK && fall) ack_err <= filt[1];
    end
  end

  assign tx_ready    = (state == IDLE) && !reset;
  assign ps2_clk_oe  = (state == TX_INHIBIT);
  assign ps2_data_oe = (state == TX_REQUEST) || (state == TX_BITS && !tx_shift[0]);

  // Receive FIFO: extra pointer MSB distinguishes full from empty.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, pop, frame_ok, push;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid = (wr_ptr != rd_ptr);
  assign pop      = rx_valid && rx_ready;
  assign frame_ok = !rx_shift[0] && rx_shift[10] && (^rx_shift[9:1]);
  assign push     = rx_done && frame_ok && (!full || pop);

  assign rx_byte     = rx_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign rx_error    = (rx_done && !frame_ok) || rx_to;
  assign rx_overflow = rx_done && frame_ok && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_shift[8:1];
  end

endmodule

// File: tb/tb_ps2_link.sv
// Directed bench for ps2_link: open-drain device model, receive/transmit frames, timeouts, glitch rejection.
module tb_ps2_link;

  localparam int FILTER  = 4;
  localparam int DEPTH   = 8;
  localparam int INHIBIT = 200;
  localparam int TOUT    = 600;
  localparam int HALF    = 30;

  logic       clk, reset;
  logic       ps2_clk_in, ps2_clk_oe, ps2_data_in, ps2_data_oe;
  logic       tx_valid, tx_ready, tx_done_valid, tx_done_error;
  logic [7:0] tx_byte, rx_byte;
  logic       rx_valid, rx_ready, rx_error, rx_overflow;
  logic       dev_clk, dev_data;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  logic [7:0] exp_q[$];

  // Wired-AND open-drain lines.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_link #(
    .FILTER(FILTER), .FIFO_DEPTH(DEPTH), .INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .ps2_clk_in(ps2_clk_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_in(ps2_data_in), .ps2_data_oe(ps2_data_oe),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
    .tx_done_valid(tx_done_valid), .tx_done_error(tx_done_error),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_byte(rx_byte),
    .rx_error(rx_error), .rx_overflow(rx_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rx_error)    err_cnt++;
    if (rx_overflow) ovf_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dev_bit(input logic b);
    dev_data = b;
    wait_cyc(HALF);
    dev_clk = 1'b0;
    wait_cyc(HALF);
    dev_clk = 1'b1;
  endtask

  task automatic dev_send(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) dev_bit(f[i]);
    dev_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_byte"}, rx_byte, e);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic start_tx(input logic [7:0] b);
    check("tx_ready_before_cmd", tx_ready, 1);
    tx_valid = 1'b1;
    tx_byte  = b;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output logic seen, output logic err);
    seen = 1'b0;
    err  = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (tx_done_valid) begin
        seen = 1'b1;
        err  = tx_done_error;
        break;
      end
    end
  endtask

  initial begin
    int         base_err, base_ovf, cnt;
    logic [9:0] txbits;
    logic       seen, derr;

    reset = 1'b1; tx_valid = 1'b0; tx_byte = 8'h00; rx_ready = 1'b0;
    dev_clk = 1'b1; dev_data = 1'b1;
    wait_cyc(4);
    check("reset_tx_ready", tx_ready, 0);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_byte", rx_byte, 0);
    check("reset_tx_done", tx_done_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    check("tx_ready_after_reset", tx_ready, 1);
    wait_cyc(10);

    // Valid frame 0x1C.
    base_err = err_cnt;
    dev_send(8'h1C, 1'b0);
    exp_q.push_back(8'h1C);
    check("rx1c_no_error", err_cnt - base_err, 0);
    pop_check("rx1c");
    check("rx1c_empty_after_pop", rx_valid, 0);

    // Bad parity frame.
    base_err = err_cnt;
    dev_send(8'h1C, 1'b1);
    check("badpar_error_pulses", err_cnt - base_err, 1);
    check("badpar_fifo_empty", rx_valid, 0);

    // Fill FIFO and overflow by one.
    base_ovf = ovf_cnt;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      dev_send(8'(i), 1'b0);
      if (i <= DEPTH) exp_q.push_back(8'(i));
    end
    check("overflow_pulses", ovf_cnt - base_ovf, 1);
    check("head_held_stable", rx_byte, 8'h01);
    for (int i = 0; i < DEPTH; i++) pop_check("fifo_drain");
    check("fifo_empty_after_drain", rx_valid, 0);

    // Transmit 0xED with a clocking, acking device.
    start_tx(8'hED);
    check("tx_ready_low_busy", tx_ready, 0);
    cnt = 0;
    for (int i = 0; i < INHIBIT + 50; i++) begin
      if (ps2_clk_oe) cnt++;
      else if (cnt > 0) break;
      @(negedge clk);
    end
    check("inhibit_length", cnt, INHIBIT);
    check("request_start_bit", ps2_data_oe, 1);
    wait_cyc(20);
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      wait_cyc(HALF);
      txbits[k] = ~ps2_data_oe;
      dev_clk = 1'b1;
      wait_cyc(HALF);
    end
    check("tx_bits_ed_parity_stop", txbits, 10'h3ED);
    dev_data = 1'b0;
    wait_cyc(5);
    dev_clk = 1'b0;
    wait_cyc(HALF);
    dev_clk = 1'b1;
    wait_cyc(HALF);
    dev_data = 1'b1;
    wait_done(100, seen, derr);
    check("tx_ed_done_seen", seen, 1);
    check("tx_ed_done_error", derr, 0);
    wait_cyc(5);

    // Transmit 0xF4, device silent.
    start_tx(8'hF4);
    wait_done(INHIBIT + TOUT + 100, seen, derr);
    check("tx_f4_done_seen", seen, 1);
    check("tx_f4_done_error", derr, 1);
    @(negedge clk);
    check("tx_f4_clk_oe_released", ps2_clk_oe, 0);
    check("tx_f4_data_oe_released", ps2_data_oe, 0);
    check("tx_f4_back_idle", tx_ready, 1);

    // Device stops clocking after four receive bits.
    base_err = err_cnt;
    dev_bit(1'b0); dev_bit(1'b1); dev_bit(1'b0); dev_bit(1'b1);
    dev_data = 1'b1;
    wait_cyc(TOUT + 100);
    check("rx_timeout_error", err_cnt - base_err, 1);
    check("rx_timeout_fifo_empty", rx_valid, 0);
    check("rx_timeout_idle", tx_ready, 1);

    // Clock glitch shorter than the filter.
    dev_clk = 1'b0;
    wait_cyc(FILTER - 1);
    dev_clk = 1'b1;
    wait_cyc(20);
    check("glitch_still_idle", tx_ready, 1);
    base_err = err_cnt;
    dev_send(8'h5A, 1'b0);
    exp_q.push_back(8'h5A);
    check("post_glitch_no_error", err_cnt - base_err, 0);
    pop_check("post_glitch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
